// File: rtl/axi_host_port_ctrl_pkg.sv
// axi_host_pkg: shared widths, AXI encodings, APB register map and A-channel payload type
package axi_host_pkg;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_e;
  typedef enum logic [1:0] {RESP_OKAY = 2'd0, RESP_EXOKAY = 2'd1, RESP_SLVERR = 2'd2, RESP_DECERR = 2'd3} resp_e;
  localparam int REG_CTRL = 'h00;
  localparam int REG_STATUS = 'h04;
  localparam int REG_ACNT = 'h08;
  localparam int REG_BCNT = 'h0C;
  localparam int REG_LASTB = 'h10;
  localparam int REG_ERRCNT = 'h14;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } a_payload_t;
endpackage

// File: rtl/axi_host_port_ctrl_if.sv
// axi_host_port_ctrl_if: command, AXI A/B and APB signals; master is the port controller, slave its environment
interface axi_host_port_ctrl_if #(
  parameter int ID_W = axi_host_pkg::ID_W,
  parameter int ADDR_W = axi_host_pkg::ADDR_W,
  parameter int PADDR_W = 12
);
  logic cmd_valid, cmd_ready;
  logic [ID_W-1:0] cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [2:0] cmd_size;
  logic [1:0] cmd_burst;
  logic avalid, aready;
  logic [ID_W-1:0] aid;
  logic [ADDR_W-1:0] aaddr;
  logic [7:0] alen;
  logic [2:0] asize;
  logic [1:0] aburst;
  logic bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic psel, penable, pwrite;
  logic [PADDR_W-1:0] paddr;
  logic [31:0] pwdata, prdata;
  logic pready, pslverr;
  modport master (
    input cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, aready, bvalid, bid, bresp,
          psel, penable, pwrite, paddr, pwdata,
    output cmd_ready, avalid, aid, aaddr, alen, asize, aburst, bready, prdata, pready, pslverr
  );
  modport slave (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, aready, bvalid, bid, bresp,
           psel, penable, pwrite, paddr, pwdata,
    input cmd_ready, avalid, aid, aaddr, alen, asize, aburst, bready, prdata, pready, pslverr
  );
endinterface

// File: rtl/axi_host_port_ctrl_apb_regs.sv
// axi_host_port_apb_regs: zero-wait APB slave holding CTRL, outstanding tracking, counters and last B response
module axi_host_port_apb_regs #(
  parameter int ID_W = 4,
  parameter int PADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               a_hs,
  input  logic               bvalid,
  input  logic [ID_W-1:0]    bid,
  input  logic [1:0]         bresp,
  input  logic               avalid,
  output logic [7:0]         outst,
  output logic               ctrl_en,
  output logic               bready
);
  import axi_host_pkg::*;
  logic en, brdy, unexp, setup, wr, b_hs, err, mapped;
  logic is_ctrl, is_status, is_acnt, is_bcnt, is_lastb, is_errcnt;
  logic [31:0] acnt, bcnt, errcnt, rdata;
  logic [ID_W+1:0] lastb;
  logic unused_pwdata;
  assign unused_pwdata = ^pwdata[31:2];
  assign ctrl_en = en;
  assign b_hs = bvalid & bready;
  assign setup = psel & ~penable;
  assign wr = psel & penable & pwrite & pready & ~pslverr;
  assign is_ctrl = paddr == PADDR_W'(REG_CTRL);
  assign is_status = paddr == PADDR_W'(REG_STATUS);
  assign is_acnt = paddr == PADDR_W'(REG_ACNT);
  assign is_bcnt = paddr == PADDR_W'(REG_BCNT);
  assign is_lastb = paddr == PADDR_W'(REG_LASTB);
  assign is_errcnt = paddr == PADDR_W'(REG_ERRCNT);
  assign mapped = is_ctrl | is_status | is_acnt | is_bcnt | is_lastb | is_errcnt;
  assign err = ~mapped | (pwrite & is_lastb);
  assign rdata = is_ctrl   ? 32'({brdy, en}) :
                 is_status ? 32'({unexp, avalid, outst}) :
                 is_acnt   ? acnt :
                 is_bcnt   ? bcnt :
                 is_lastb  ? 32'(lastb) :
                 is_errcnt ? errcnt : '0;
  // response is registered at the setup edge so it is presented for exactly the access cycle
  always_ff @(posedge clk)
    if (rst_n) begin
      prdata <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      bready <= 1'b0;
      {brdy, en} <= 2'b11;
      unexp <= 1'b0;
      outst <= '0;
      acnt <= '0;
      bcnt <= '0;
      errcnt <= '0;
      lastb <= '0;
    end else begin
      pready <= setup;
      pslverr <= setup & err;
      prdata <= setup && !pwrite ? rdata : '0;
      bready <= brdy;
      if (wr && is_ctrl) {brdy, en} <= pwdata[1:0];
      unexp <= !(wr && is_status) && (unexp || (b_hs && outst == '0));
      outst <= outst + 8'(a_hs & ~b_hs) - 8'(b_hs & ~a_hs & (outst != '0));
      acnt <= wr && is_acnt ? '0 : acnt + 32'(a_hs);
      bcnt <= wr && is_bcnt ? '0 : bcnt + 32'(b_hs);
      errcnt <= wr && is_errcnt ? '0 : errcnt + 32'(b_hs && bresp != RESP_OKAY);
      if (b_hs) lastb <= {bid, bresp};
    end
endmodule

// File: rtl/axi_host_port_ctrl.sv
// axi_host_port_ctrl: issues host commands as single AXI address beats and tracks B responses under APB control
module axi_host_port_ctrl #(
  parameter int ID_W = axi_host_pkg::ID_W,
  parameter int ADDR_W = axi_host_pkg::ADDR_W,
  parameter int MAX_OUTST = 8,
  parameter int PADDR_W = 12
) (
  input logic clk,
  input logic rst_n,
  axi_host_port_ctrl_if.master bus
);
  import axi_host_pkg::*;
  a_payload_t a_q;
  logic avalid_q, a_hs, ctrl_en;
  logic [7:0] outst;
  assign a_hs = avalid_q & bus.aready;
  assign bus.cmd_ready = ctrl_en & (~avalid_q | bus.aready) & (({1'b0, outst} + 9'(avalid_q)) < 9'(MAX_OUTST));
  always_ff @(posedge clk)
    if (rst_n) begin
      avalid_q <= 1'b0;
      a_q <= '0;
    end else if (bus.cmd_valid && bus.cmd_ready) begin
      avalid_q <= 1'b1;
      a_q <= '{id: bus.cmd_id, addr: bus.cmd_addr, len: bus.cmd_len, size: bus.cmd_size, burst: bus.cmd_burst};
    end else if (a_hs) avalid_q <= 1'b0;
  assign bus.avalid = avalid_q;
  assign bus.aid = ID_W'(a_q.id);
  assign bus.aaddr = ADDR_W'(a_q.addr);
  assign bus.alen = a_q.len;
  assign bus.asize = a_q.size;
  assign bus.aburst = a_q.burst;
  axi_host_port_apb_regs #(.ID_W(ID_W), .PADDR_W(PADDR_W)) u_regs (
    .clk(clk),
    .rst_n(rst_n),
    .psel(bus.psel),
    .penable(bus.penable),
    .pwrite(bus.pwrite),
    .paddr(bus.paddr),
    .pwdata(bus.pwdata),
    .prdata(bus.prdata),
    .pready(bus.pready),
    .pslverr(bus.pslverr),
    .a_hs(a_hs),
    .bvalid(bus.bvalid),
    .bid(bus.bid),
    .bresp(bus.bresp),
    .avalid(avalid_q),
    .outst(outst),
    .ctrl_en(ctrl_en),
    .bready(bus.bready)
  );
endmodule

// File: tb/tb_axi_host_port_ctrl.sv
// tb_axi_host_port_ctrl: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_axi_host_port_ctrl;
  import axi_host_pkg::*;
  logic clk, rst_n;
  int total = 0, bad = 0;
  axi_host_port_ctrl_if bus();
  axi_host_port_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  a_payload_t pend[$];
  int unsigned m_outst;
  logic m_en, m_brdy, m_bready, m_unexp, m_pready, m_perr, m_pwr;
  logic [31:0] m_acnt, m_bcnt, m_err, m_prd;
  logic [5:0] m_lastb;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  function automatic logic m_mapped(input logic [11:0] a);
    return a inside {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014};
  endfunction
  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h000: return {30'b0, m_brdy, m_en};
      12'h004: return {22'b0, m_unexp, pend.size() != 0, 8'(m_outst)};
      12'h008: return m_acnt;
      12'h00C: return m_bcnt;
      12'h010: return {26'b0, m_lastb};
      12'h014: return m_err;
      default: return '0;
    endcase
  endfunction
  task automatic idle();
    bus.cmd_valid = 0; bus.cmd_id = 0; bus.cmd_addr = 0; bus.cmd_len = 0; bus.cmd_size = 0; bus.cmd_burst = 0;
    bus.aready = 0; bus.bvalid = 0; bus.bid = 0; bus.bresp = 0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
  endtask
  task automatic tick();
    logic cr, ahs, bhs, chs, setup, wr_acc, n_err;
    logic [31:0] n_rd, wd;
    logic [11:0] wa;
    logic [3:0] bid;
    logic [1:0] bresp;
    a_payload_t cp;
    #1;
    cr = m_en && (pend.size() == 0 || bus.aready) && (m_outst + pend.size() < 8);
    chk("avalid", bus.avalid, pend.size() != 0);
    if (pend.size() != 0) chk("a_payload", {bus.aid, bus.aaddr, bus.alen, bus.asize, bus.aburst}, pend[0]);
    chk("cmd_ready", bus.cmd_ready, cr);
    chk("bready", bus.bready, m_bready);
    chk("pready", bus.pready, m_pready);
    if (m_pready) begin
      chk("pslverr", bus.pslverr, m_perr);
      if (!m_pwr) chk("prdata", bus.prdata, m_prd);
    end
    chs = bus.cmd_valid && cr;
    ahs = pend.size() != 0 && bus.aready;
    bhs = bus.bvalid && m_bready;
    cp = '{id: bus.cmd_id, addr: bus.cmd_addr, len: bus.cmd_len, size: bus.cmd_size, burst: bus.cmd_burst};
    bid = bus.bid; bresp = bus.bresp;
    setup = bus.psel && !bus.penable;
    wr_acc = bus.psel && bus.penable && bus.pwrite && m_pready && !m_perr;
    n_err = !m_mapped(bus.paddr) || (bus.pwrite && bus.paddr == 12'h010);
    n_rd = m_read(bus.paddr);
    wa = bus.paddr; wd = bus.pwdata;
    @(posedge clk);
    if (ahs) begin void'(pend.pop_front()); m_acnt++; end
    if (chs) pend.push_back(cp);
    if (bhs) begin
      m_bcnt++;
      if (bresp != 0) m_err++;
      m_lastb = {bid, bresp};
      if (m_outst == 0) m_unexp = 1;
    end
    if (ahs && !bhs) m_outst++;
    else if (bhs && !ahs && m_outst > 0) m_outst--;
    m_bready = m_brdy;
    if (wr_acc)
      case (wa)
        12'h000: {m_brdy, m_en} = wd[1:0];
        12'h004: m_unexp = 0;
        12'h008: m_acnt = 0;
        12'h00C: m_bcnt = 0;
        12'h014: m_err = 0;
        default: ;
      endcase
    m_pready = setup; m_perr = setup && n_err; m_prd = n_rd; m_pwr = bus.pwrite;
    @(negedge clk);
  endtask
  task automatic do_reset();
    idle();
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    pend.delete();
    m_outst = 0; m_en = 1; m_brdy = 1; m_bready = 0; m_unexp = 0;
    m_acnt = 0; m_bcnt = 0; m_err = 0; m_lastb = 0;
    m_pready = 0; m_perr = 0; m_prd = 0; m_pwr = 0;
    #1;
    chk("rst_avalid", bus.avalid, 0);
    chk("rst_apayload", {bus.aid, bus.aaddr, bus.alen, bus.asize, bus.aburst}, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_pready", bus.pready, 0);
    chk("rst_pslverr", bus.pslverr, 0);
    chk("rst_prdata", bus.prdata, 0);
  endtask
  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d, output logic [31:0] rd, output logic err);
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    tick();
    bus.penable = 1;
    #1;
    rd = bus.prdata;
    err = bus.pslverr;
    tick();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] r;
    logic e;
    logic [11:0] addrs [8];
    addrs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h020};
    do_reset();
    tick();
    apb(0, 12'h000, 0, r, e); chk("ctrl_reset", r, 3);
    bus.cmd_valid = 1; bus.cmd_addr = 0; bus.aready = 1;
    tick();
    bus.cmd_valid = 0;
    #1 chk("t1_avalid", bus.avalid, 1); chk("t1_aaddr", bus.aaddr, 0);
    tick();
    #1 chk("t1_avalid_drop", bus.avalid, 0);
    bus.aready = 0;
    apb(0, 12'h008, 0, r, e); chk("t1_acnt", r, 1);
    apb(0, 12'h004, 0, r, e); chk("t1_outst", r[7:0], 1);
    bus.cmd_valid = 1; bus.cmd_addr = 32'h4;
    tick();
    bus.cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_aaddr_stable", bus.aaddr, 32'h4); chk("t2_cmd_ready", bus.cmd_ready, 0);
      tick();
    end
    bus.aready = 1;
    #1 chk("t2_handshake", bus.avalid && bus.aready, 1);
    tick();
    bus.cmd_valid = 1;
    for (int i = 0; i < 40 && m_outst < 8; i++) begin
      bus.cmd_addr = 32'(i * 4);
      tick();
    end
    #1 chk("t3_full_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 0; bus.aready = 0;
    apb(0, 12'h004, 0, r, e); chk("t3_outst8", r[7:0], 8);
    bus.bvalid = 1; bus.bid = 0; bus.bresp = 0;
    tick();
    bus.bvalid = 0;
    #1 chk("t3_ready_again", bus.cmd_ready, 1);
    apb(0, 12'h004, 0, r, e); chk("t3_outst7", r[7:0], 7);
    bus.bvalid = 1; bus.bid = 5; bus.bresp = 2;
    tick();
    bus.bvalid = 0;
    apb(0, 12'h014, 0, r, e); chk("t4_errcnt", r, 1);
    apb(0, 12'h010, 0, r, e); chk("t4_lastb", r, 32'h16);
    apb(1, 12'h014, 32'hFFFF_FFFF, r, e);
    apb(0, 12'h014, 0, r, e); chk("t4_errcnt_clr", r, 0);
    bus.cmd_valid = 1; bus.cmd_addr = 32'h100;
    tick();
    bus.cmd_valid = 0; bus.aready = 1; bus.bvalid = 1; bus.bid = 1; bus.bresp = 0;
    tick();
    bus.aready = 0; bus.bvalid = 0;
    apb(0, 12'h004, 0, r, e); chk("t5_outst_same", r[7:0], 6);
    bus.bvalid = 1;
    for (int i = 0; i < 20 && m_outst > 0; i++) tick();
    tick();
    bus.bvalid = 0;
    apb(0, 12'h004, 0, r, e); chk("t5_unexp", r, 32'h200);
    apb(1, 12'h004, 0, r, e);
    apb(0, 12'h004, 0, r, e); chk("t5_unexp_clr", r, 0);
    apb(0, 12'h020, 0, r, e); chk("t6_unmapped_err", e, 1); chk("t6_unmapped_data", r, 0);
    apb(1, 12'h010, 32'h3F, r, e); chk("t6_lastb_wr_err", e, 1);
    apb(0, 12'h010, 0, r, e); chk("t6_lastb_kept", r, 32'h4);
    apb(1, 12'h000, 0, r, e);
    bus.cmd_valid = 1;
    #1 chk("t6_cmd_blocked", bus.cmd_ready, 0);
    bus.cmd_valid = 0;
    tick();
    #1 chk("t6_bready_off", bus.bready, 0);
    apb(1, 12'h000, 3, r, e);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        bus.cmd_valid = 1; bus.aready = 0;
        tick();
        do_reset();
        apb(0, 12'h004, 0, r, e); chk("mid_rst_status", r, 0);
        apb(0, 12'h008, 0, r, e); chk("mid_rst_acnt", r, 0);
      end
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_id = 4'($urandom); bus.cmd_addr = $urandom; bus.cmd_len = 8'($urandom);
      bus.cmd_size = 3'($urandom); bus.cmd_burst = 2'($urandom);
      bus.aready = $urandom_range(0, 3) != 0;
      bus.bvalid = $urandom_range(0, 2) == 0;
      bus.bid = 4'($urandom); bus.bresp = 2'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        logic [11:0] a;
        logic wr;
        a = addrs[$urandom_range(0, 7)];
        wr = $urandom_range(0, 3) == 0;
        apb(wr, a, (a == 12'h000 && $urandom_range(0, 3) != 0) ? 32'h3 : $urandom, r, e);
      end else tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_host_port_ctrl.md
Name: axi_host_port_ctrl

Overview:
- Host-side AXI request port with APB-programmable control and status.
- Accepts simple commands (id, addr, len, size, burst) and issues each as one AXI address-channel beat (AR or AW style) with valid/ready handshake.
- Sinks AXI write-response (B) beats and tracks outstanding transactions.
- Exposes control, counters and last-response status through a zero-wait APB slave; sits between test/host logic and the memory controller's AXI port.

Parameters:
- ID_W, 4, AXI ID width.
- ADDR_W, 32, AXI address width.
- MAX_OUTST, 8, maximum outstanding A-without-B transactions (power of 2, ≤255).
- PADDR_W, 12, APB address width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset); name kept for codebase consistency.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_id  in  ID_W  command ID.
- cmd_addr  in  ADDR_W  command address.
- cmd_len  in  8  burst length minus 1.
- cmd_size  in  3  log2 bytes per beat.
- cmd_burst  in  2  burst type (0 FIXED, 1 INCR, 2 WRAP); passed through unchecked.
- avalid  out  1  AXI A-channel valid.
- aready  in  1  AXI A-channel ready.
- aid/aaddr/alen/asize/aburst  out  ID_W/ADDR_W/8/3/2  AXI A-channel payload.
- bvalid  in  1  AXI B valid.
- bready  out  1  AXI B ready.
- bid  in  ID_W  B ID.
- bresp  in  2  B response.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  PADDR_W  APB address.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.

Behaviour:
- Reset: avalid=0; A payload=0; bready=0; prdata=0; pslverr=0; pready=0; all counters 0; CTRL=0x3.
- Command path, single-entry A register:
  - cmd_ready = CTRL.EN & (!avalid | aready) & (outst + avalid < MAX_OUTST).
  - On cmd handshake, load payload and set avalid the next cycle (1-cycle latency).
  - Payload is stable while avalid & !aready.
  - A handshake (avalid & aready) clears avalid unless a new command loads in the same cycle, giving back-to-back issue.
- CTRL.EN=0 blocks new commands; an already-pending avalid still completes.
- bready = CTRL.BRDY (registered copy of the CTRL bit).
- Outstanding count (outst):
  - +1 on A handshake; −1 on B handshake; unchanged when both occur in the same cycle.
  - A B handshake with outst=0 does not underflow; it sets sticky STATUS.UNEXP.
- Counters, 32-bit, wrap at 2^32:
  - ACNT counts A handshakes.
  - BCNT counts B handshakes.
  - ERRCNT counts B handshakes with bresp≠0.
  - LASTB captures {bid, bresp} on every B handshake.
- APB:
  - Setup phase (psel & !penable) produces no response.
  - Access phase (psel & penable): pready=1 for exactly that cycle (zero wait). Registered response: pready/prdata/pslverr driven one cycle after psel & !penable; hold penable until pready.
  - Reads return the register value.
  - Writes:
    - 0x00 CTRL: bit0 EN, bit1 BRDY, other bits read 0.
    - 0x08/0x0C/0x14: any write clears that counter; a same-cycle event is lost to the clear.
    - 0x04 write: clears STATUS.UNEXP.
  - Register map:
    - 0x04 STATUS (RO): [7:0] outst, [8] avalid, [9] UNEXP.
    - 0x08 ACNT.
    - 0x0C BCNT.
    - 0x10 LASTB (RO): [1:0] bresp, [ID_W+1:2] bid.
    - 0x14 ERRCNT.
  - Unmapped address, or write to LASTB: pslverr=1, prdata=0, no state change.
- Reset asserted mid-operation: pending A beat dropped; all state returns to reset values the next cycle.

Decomposition:
- Package axi_host_pkg:
  - ID_W, ADDR_W and AXI burst-type constants (FIXED/INCR/WRAP).
  - BRESP constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
  - APB register offset constants.
  - A-payload packed struct {id, addr, len, size, burst}.
- One sub-module, axi_host_port_apb_regs: the APB decode, CTRL/STATUS/counter registers, and pslverr generation.

Test Plan:
- Reset release, then cmd (id=0, addr=0x0, len=0, size=0, burst=0) with aready=1 → avalid high for 1 cycle with aaddr=0; ACNT reads 1; STATUS.outst reads 1.
- Second cmd (id=0, addr=0x4) issued back-to-back with aready held 0 for 3 cycles → aaddr=0x4 stable all 3 cycles; cmd_ready=0 throughout; handshake on the 4th cycle.
- Issue MAX_OUTST=8 commands with no B → cmd_ready=0 at outst=8. One B beat (bid=0, bresp=0) → outst=7, cmd_ready=1.
- B beat bresp=2 (SLVERR), bid=5 → ERRCNT=1; LASTB=0x16. Write 0x14 → ERRCNT reads 0.
- A and B handshakes in the same cycle → outst unchanged. B with outst=0 → STATUS.UNEXP=1, outst stays 0.
- APB read of 0x20 → pslverr=1, prdata=0. Write CTRL=0 → cmd_ready=0 and bready=0.
